// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stalls, multi-cycle data-memory freezes and
// taken-branch flushes, with saturating per-class event counters.
module hazard_stall_unit #(
    parameter int REG_AW    = 5,
    parameter int MEM_LAT   = 0,
    parameter int ZERO_SKIP = 1,
    parameter int PERF_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_id_rs_addr,
    input  logic [REG_AW-1:0] i_id_rt_addr,
    input  logic              i_id_uses_rs,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rt_addr,
    input  logic              i_mem_access,
    input  logic              i_ex_branch_taken,
    input  logic              i_perf_clr,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_id_ex_bubble,
    output logic              o_if_id_flush,
    output logic              o_pipe_freeze,
    output logic [PERF_W-1:0] o_stall_count,
    output logic [PERF_W-1:0] o_flush_count,
    output logic [PERF_W-1:0] o_freeze_count
);

    localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(MEM_LAT);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt);
        sat_inc = (cnt == PERF_MAX) ? cnt : cnt + PERF_W'(1'b1);
    endfunction

    logic [LAT_W-1:0]  r_lat_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;
    logic [PERF_W-1:0] r_freeze_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_zero_ok;
    logic w_lu;
    logic w_freeze;
    logic w_freeze_evt;
    logic w_flush_evt;
    logic w_stall_evt;

    assign w_rs_hit  = i_id_uses_rs && (i_ex_rt_addr == i_id_rs_addr);
    assign w_rt_hit  = i_id_uses_rt && (i_ex_rt_addr == i_id_rt_addr);
    assign w_zero_ok = (ZERO_SKIP == 0) || (i_ex_rt_addr != {REG_AW{1'b0}});
    assign w_lu      = i_ex_mem_read && (w_rs_hit || w_rt_hit) && w_zero_ok;
    assign w_freeze  = i_mem_access && (r_lat_cnt != LAT_MAX);

    // Granted events after priority resolution (rst > freeze > branch > load-use)
    assign w_freeze_evt = !i_rst && w_freeze;
    assign w_flush_evt  = !i_rst && !w_freeze && i_ex_branch_taken;
    assign w_stall_evt  = !i_rst && !w_freeze && !i_ex_branch_taken && w_lu;

    // Pipeline control outputs from the resolved hazard class
    always_comb begin
        o_pc_write     = 1'b1;
        o_if_id_write  = 1'b1;
        o_id_ex_bubble = 1'b0;
        o_if_id_flush  = 1'b0;
        o_pipe_freeze  = 1'b0;
        if (i_rst) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
        end else if (w_freeze_evt) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_pipe_freeze = 1'b1;
        end else if (w_flush_evt) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
        end else if (w_stall_evt) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
        end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
        end
    end

    // Memory latency counter: counts wait cycles, clears when the access completes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lat_cnt <= {LAT_W{1'b0}};
        end else if (w_freeze) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1'b1);
        end else begin
            r_lat_cnt <= {LAT_W{1'b0}};
        end
    end

    // Saturating event counters; clear wins over increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_perf_clr) begin
            r_stall_cnt  <= {PERF_W{1'b0}};
            r_flush_cnt  <= {PERF_W{1'b0}};
            r_freeze_cnt <= {PERF_W{1'b0}};
        end else begin
            r_stall_cnt  <= w_stall_evt  ? sat_inc(r_stall_cnt)  : r_stall_cnt;
            r_flush_cnt  <= w_flush_evt  ? sat_inc(r_flush_cnt)  : r_flush_cnt;
            r_freeze_cnt <= w_freeze_evt ? sat_inc(r_freeze_cnt) : r_freeze_cnt;
        end
    end

    assign o_stall_count  = r_stall_cnt;
    assign o_flush_count  = r_flush_cnt;
    assign o_freeze_count = r_freeze_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two configurations driven by shared stimulus and
// checked against a reference model built on access-run positions.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst, uses_rs, uses_rt, mem_read, mem_access, br_taken, perf_clr;
    logic [4:0] rs_addr, rt_addr, ex_rt;

    logic [4:0]  outs0, outs1;
    logic [15:0] stall0, flush0, freeze0;
    logic [1:0]  stall1, flush1, freeze1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state, index 0 = single-cycle memory config, 1 = MEM_LAT=3 / PERF_W=2 / no zero skip
    int lat[2]  = '{0, 3};
    int zs[2]   = '{1, 0};
    int cmax[2] = '{65535, 3};
    int run_pos[2];
    int m_stall[2];
    int m_flush[2];
    int m_freeze[2];

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_AW(5), .MEM_LAT(0), .ZERO_SKIP(1), .PERF_W(16)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_id_rs_addr(rs_addr), .i_id_rt_addr(rt_addr),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_ex_mem_read(mem_read),
        .i_ex_rt_addr(ex_rt), .i_mem_access(mem_access), .i_ex_branch_taken(br_taken),
        .i_perf_clr(perf_clr), .o_pc_write(outs0[4]), .o_if_id_write(outs0[3]),
        .o_id_ex_bubble(outs0[2]), .o_if_id_flush(outs0[1]), .o_pipe_freeze(outs0[0]),
        .o_stall_count(stall0), .o_flush_count(flush0), .o_freeze_count(freeze0)
    );

    hazard_stall_unit #(.REG_AW(5), .MEM_LAT(3), .ZERO_SKIP(0), .PERF_W(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_id_rs_addr(rs_addr), .i_id_rt_addr(rt_addr),
        .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_ex_mem_read(mem_read),
        .i_ex_rt_addr(ex_rt), .i_mem_access(mem_access), .i_ex_branch_taken(br_taken),
        .i_perf_clr(perf_clr), .o_pc_write(outs1[4]), .o_if_id_write(outs1[3]),
        .o_id_ex_bubble(outs1[2]), .o_if_id_flush(outs1[1]), .o_pipe_freeze(outs1[0]),
        .o_stall_count(stall1), .o_flush_count(flush1), .o_freeze_count(freeze1)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One cycle: drive, check both instances against the model, advance the model
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mr, input logic [4:0] ert,
                        input logic ma, input logic br, input logic clr);
        logic fz, lu, st;
        logic [4:0] e;
        rst = r; rs_addr = rs; rt_addr = rt; uses_rs = urs; uses_rt = urt;
        mem_read = mr; ex_rt = ert; mem_access = ma; br_taken = br; perf_clr = clr;
        #1;
        for (int k = 0; k < 2; k++) begin
            // Within a run of consecutive accesses, every (lat+1)-th cycle completes one
            fz = ma && ((run_pos[k] % (lat[k] + 1)) != lat[k]);
            lu = mr && ((urs && ert == rs) || (urt && ert == rt)) && (zs[k] == 0 || ert != 5'd0);
            st = 1'b0;
            if (r)       e = 5'b00100;
            else if (fz) e = 5'b00001;
            else if (br) e = 5'b11110;
            else if (lu) begin e = 5'b00100; st = 1'b1; end
            else         e = 5'b11000;
            chk("outs",   k, (k == 0) ? 32'(outs0)   : 32'(outs1),   32'(e));
            chk("stall",  k, (k == 0) ? 32'(stall0)  : 32'(stall1),  32'(m_stall[k]));
            chk("flush",  k, (k == 0) ? 32'(flush0)  : 32'(flush1),  32'(m_flush[k]));
            chk("freeze", k, (k == 0) ? 32'(freeze0) : 32'(freeze1), 32'(m_freeze[k]));
            if (r || clr) begin
                m_stall[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
            end else begin
                if (st && m_stall[k] < cmax[k])               m_stall[k]++;
                if (!fz && br && m_flush[k] < cmax[k])        m_flush[k]++;
                if (fz && m_freeze[k] < cmax[k])              m_freeze[k]++;
            end
            run_pos[k] = (r || !ma) ? 0 : run_pos[k] + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            run_pos[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
        end
        rst = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
        mem_read = 1'b0; ex_rt = 5'd0; mem_access = 1'b0; br_taken = 1'b0; perf_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Load-use on rs, then the bubble cycle
        step(1'b0, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // $zero load; rt-only match with rt unused
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        // Load-use coinciding with a taken branch
        step(1'b0, 5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        // Two back-to-back accesses, load-use and branch present during the freeze
        for (int i = 0; i < 8; i++)
            step(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, (i < 3), 5'd7, 1'b1, (i == 1), 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Reset landing on the second freeze cycle, then a full access
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, (i < 4), 1'b0, 1'b0);
        // Five stalls saturate the narrow counter, then clear alongside a stall
        for (int i = 0; i < 5; i++)
            step(1'b0, 5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 29) == 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Successor to the single-cycle load-use detector for the 5-stage MIPS pipeline.
- Handles three hazard classes from one block:
  - load-use stalls, with generalised register-address width and $zero/operand-use qualification;
  - multi-cycle data-memory freezes, using a latency counter;
  - taken-branch flushes.
- Keeps saturating performance counters for each hazard class.
- Sits between the ID/EX/MEM pipeline registers and the PC/IF-ID write enables.

Parameters:
- REG_AW, 5: register address width.
- MEM_LAT, 0: extra wait cycles per data-memory access (0..255); 0 means single-cycle memory, never freeze.
- ZERO_SKIP, 1: if 1, a load targeting register 0 never causes a stall.
- PERF_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs_addr  in  REG_AW  rs of instruction in ID (IF/ID output)
- id_rt_addr  in  REG_AW  rt of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load (ID/EX MemRead)
- ex_rt_addr  in  REG_AW  load destination in EX
- mem_access  in  1  instruction in MEM performs a data-memory read or write
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- perf_clr  in  1  synchronous clear of performance counters
- pc_write  out  1  PC write enable
- if_id_write  out  1  IF/ID write enable
- id_ex_bubble  out  1  zero all control bits entering ID/EX
- if_id_flush  out  1  clear IF/ID to NOP
- pipe_freeze  out  1  hold ID/EX, EX/MEM and PC/IF-ID; insert bubble into MEM/WB
- stall_count  out  PERF_W  load-use stall cycles
- flush_count  out  PERF_W  branch flush events
- freeze_count  out  PERF_W  memory freeze cycles

Behaviour:
- Reset:
  - While rst=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_freeze=0.
  - Latency counter (lat_cnt) and all perf counters go to 0 on the clock edge.
- Load-use detect (combinational):
  - lu = ex_mem_read & ((id_uses_rs & ex_rt_addr==id_rs_addr) | (id_uses_rt & ex_rt_addr==id_rt_addr)).
  - When ZERO_SKIP=1, lu is also gated by ex_rt_addr!=0.
- Memory freeze:
  - lat_cnt register, width clog2(MEM_LAT+1), minimum 1.
  - freeze = mem_access & (lat_cnt != MEM_LAT).
  - Each clock:
    - if freeze: lat_cnt <= lat_cnt+1;
    - else if mem_access: lat_cnt <= 0 (access completes, instruction advances);
    - else lat_cnt holds 0.
  - Each access therefore freezes exactly MEM_LAT cycles.
  - Back-to-back accesses each freeze MEM_LAT cycles with no gap cycle lost.
  - MEM_LAT=0 never freezes.
- Output priority, highest first (rst > freeze > branch > load-use):
  - freeze: pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0. Branch and load-use are ignored this cycle and re-evaluated after the freeze.
  - ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. Load-use is suppressed because the ID instruction is wrong-path.
  - lu: pc_write=0, if_id_write=0, id_ex_bubble=1, for exactly one cycle. The next cycle the load is in MEM and the bubble is in EX, so lu falls naturally.
  - Otherwise: pc_write=1, if_id_write=1, all others 0.
- Performance counters:
  - Each counter increments by 1 on cycles where its effective output event is asserted:
    - stall_count: lu granted;
    - flush_count: if_id_flush;
    - freeze_count: pipe_freeze.
  - Counters saturate at all-ones.
  - perf_clr has priority over increment; rst has priority over both.
- Reset mid-freeze: lat_cnt returns to 0; the first access after reset freezes the full MEM_LAT cycles.

Test Plan:
1. MEM_LAT=0: load to $t1 in EX, ID add uses rs=$t1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all normal; stall_count=1.
2. Load to $0 with ID reading $0, ZERO_SKIP=1 -> no stall. Same case with id_uses_rt=0 and rt match only -> no stall.
3. Load-use and ex_branch_taken in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_count unchanged; flush_count=1.
4. MEM_LAT=3, mem_access held 4 cycles -> pipe_freeze=1,1,1,0; freeze_count=3. Then a second access immediately after -> three more freeze cycles; freeze_count=6.
5. MEM_LAT=3: assert rst during the 2nd freeze cycle -> reset output values and lat_cnt=0. Access after reset -> full 3 freeze cycles.
6. PERF_W=2: 5 stall events -> stall_count=3 (saturated). perf_clr asserted together with a stall -> stall_count=0.
